// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the LTC2308 responder emulation.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_responder_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONV     = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_SHIFT    = 2'd3
  } state_e;

  // Bit positions inside the config word, MSB first as shifted in on SDI
  localparam int CFG_SD  = 5;  // 1 = single-ended, 0 = differential
  localparam int CFG_OS  = 4;  // odd/sign, low bit of the channel index
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;  // 1 = unipolar, 0 = bipolar
  localparam int CFG_SLP = 0;  // sleep request, reported only

  // Config after reset: single-ended CH0, unipolar, awake
  localparam logic [5:0] CFG_RESET = 6'b100010;

  // Number of selectable channels
  localparam int NUM_CHAN = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Pin synchronizer with registered rise/fall pulses and an aligned level.
// Latency: pin change to pulse/level is STAGES+1 clk cycles.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Metastability chain, then one flop of history to form edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(pin_i);
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  // prev_q updates on the same edge as the pulses, so level and events line up
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Fabric-side LTC2308 emulator: answers CONVST/SCLK/SDI with results from loadable channel registers.
// Latency: SDO updates SYNC_STAGES+2 cycles after an SCLK fall; busy spans CONV_CYCLES cycles.
// Backpressure: none; the master must respect minimum SCLK/CONVST phase widths.
module adc_spi_responder
  import adc_responder_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 160
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adc_convst,
  input  logic              adc_sclk,
  input  logic              adc_din,
  output logic              adc_dout,
  input  logic              chan_wr_en,
  input  logic [2:0]        chan_wr_sel,
  input  logic [DATA_W-1:0] chan_wr_data,
  output logic              busy,
  output logic              cfg_valid,
  output logic [CFG_W-1:0]  cfg_word
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int RC_W  = $clog2(CFG_W + 1);

  // Synchronized pin views
  logic conv_level, conv_rise, conv_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic din_level, din_rise, din_fall;

  // Sequencer state and registered outputs
  state_e              state_q;
  logic [CNT_W-1:0]    conv_cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                dout_q;
  logic                busy_q;
  logic [CFG_W-1:0]    cfg_sh_q;
  logic [RC_W-1:0]     rise_cnt_q;
  logic [CFG_W-1:0]    cfg_word_q;
  logic                cfg_valid_q;

  // Software-loaded conversion results
  logic [DATA_W-1:0]   chan_q [NUM_CHAN];

  // Sample that a CONVST rise would latch right now
  logic [2:0]          chan_sel;
  logic [DATA_W-1:0]   sample_d;

  logic                unused_edges;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (adc_convst),
    .level_o (conv_level),
    .rise_o  (conv_rise),
    .fall_o  (conv_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (adc_sclk),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (adc_din),
    .level_o (din_level),
    .rise_o  (din_rise),
    .fall_o  (din_fall)
  );

  // SDI is only sampled as a level and SCLK only as edges
  assign unused_edges = din_rise | din_fall | sclk_level;

  // Channel registers; a write coinciding with a latch lands after the latch reads the old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        chan_q[i] <= '0;
      end
    end else if (chan_wr_en) begin
      chan_q[chan_wr_sel] <= chan_wr_data;
    end
  end

  // Build the sample from the config captured in the previous frame
  always_comb begin
    chan_sel = {cfg_word_q[CFG_S1], cfg_word_q[CFG_S0], cfg_word_q[CFG_OS]};
    sample_d = '0;
    if (cfg_word_q[CFG_SD]) begin
      sample_d = chan_q[chan_sel];
    end
    // Bipolar: flipping the MSB re-centres offset binary into two's complement
    if (!cfg_word_q[CFG_UNI]) begin
      sample_d[DATA_W-1] = ~sample_d[DATA_W-1];
    end
  end

  // Frame sequencer: conversion timing, SDO shifting and SDI config capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      conv_cnt_q  <= '0;
      data_q      <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_sh_q    <= '0;
      rise_cnt_q  <= '0;
      cfg_word_q  <= CFG_W'(CFG_RESET);
      cfg_valid_q <= 1'b0;
    end else begin
      cfg_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
          busy_q <= 1'b0;
          if (conv_rise) begin
            data_q     <= sample_d;
            conv_cnt_q <= CNT_W'(CONV_CYCLES - 1);
            busy_q     <= 1'b1;
            state_q    <= ST_CONV;
          end
        end

        ST_CONV: begin
          dout_q <= 1'b0;
          if (conv_cnt_q == '0) begin
            busy_q <= 1'b0;
            if (!conv_level) begin
              // CONVST already back low: present the MSB straight away
              state_q    <= ST_SHIFT;
              dout_q     <= data_q[DATA_W-1];
              rise_cnt_q <= '0;
              cfg_sh_q   <= '0;
            end else begin
              state_q <= ST_WAIT_LOW;
            end
          end else begin
            conv_cnt_q <= conv_cnt_q - 1'b1;
          end
        end

        ST_WAIT_LOW: begin
          dout_q <= 1'b0;
          busy_q <= 1'b0;
          if (conv_fall) begin
            state_q    <= ST_SHIFT;
            dout_q     <= data_q[DATA_W-1];
            rise_cnt_q <= '0;
            cfg_sh_q   <= '0;
          end
        end

        ST_SHIFT: begin
          if (conv_rise) begin
            // New frame aborts any unfinished shifting; a partial config is dropped
            data_q     <= sample_d;
            conv_cnt_q <= CNT_W'(CONV_CYCLES - 1);
            busy_q     <= 1'b1;
            dout_q     <= 1'b0;
            state_q    <= ST_CONV;
          end else begin
            // Zero fill means SDO reads 0 once all result bits have gone
            if (sclk_fall) begin
              data_q <= data_q << 1;
              dout_q <= data_q[DATA_W-2];
            end
            if (sclk_rise && (rise_cnt_q < RC_W'(CFG_W))) begin
              cfg_sh_q   <= {cfg_sh_q[CFG_W-2:0], din_level};
              rise_cnt_q <= rise_cnt_q + 1'b1;
              if (rise_cnt_q == RC_W'(CFG_W - 1)) begin
                cfg_word_q  <= {cfg_sh_q[CFG_W-2:0], din_level};
                cfg_valid_q <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_dout  = dout_q;
  assign busy      = busy_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_word  = cfg_word_q;

endmodule
